// File: rtl/cpu_pkg.sv
// Shared arbitration constants and a width helper for channel-index buses.
package cpu_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // $clog2 returns 0 for n<=1, which would produce a zero-width index bus.
  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_mux_n_rr_pick.sv
// Rotating-priority picker. It scans req starting at base+1 and wraps modulo
// NUM_CH, so base is the lowest-priority position. With base tied to NUM_CH-1
// it behaves as a fixed lowest-index-wins priority encoder.
module rr_pick
  import cpu_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = safe_clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   base,
  output logic [NUM_CH-1:0] gnt,
  output logic [CH_W-1:0]   idx,
  output logic              any
);

  // Pick the first requester after base, wrapping around.
  always_comb begin
    int c;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      c = (int'(base) + k) % NUM_CH;
      if (!any && req[c]) begin
        any    = 1'b1;
        gnt[c] = 1'b1;
        idx    = CH_W'(c);
      end
    end
  end

endmodule

// File: rtl/arb_mux_n.sv
// N-channel arbitrating multiplexer with a one-entry registered valid/ready
// output stage. Fixed priority or round-robin, one word per cycle throughput.
module arb_mux_n
  import cpu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_CH = 4,
  parameter int MODE   = 1,
  parameter int CH_W   = safe_clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CH_W-1:0]         out_ch
);

  logic [CH_W-1:0]   ptr;
  logic [CH_W-1:0]   base;
  logic [NUM_CH-1:0] gnt;
  logic [CH_W-1:0]   pick_idx;
  logic              pick_any;
  logic              space;
  logic              in_xfer;
  logic [WIDTH-1:0]  sel_data;

  // Fixed mode pins the rotation base so channel 0 always scans first.
  assign base = (MODE == ARB_RR && NUM_CH > 1) ? ptr : CH_W'(NUM_CH - 1);

  rr_pick #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_pick (
    .req  (in_valid),
    .base (base),
    .gnt  (gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // Accept only when the output register is empty or draining, never in reset.
  always_comb begin
    space    = !out_valid || out_ready;
    in_xfer  = rst_n && pick_any && space;
    in_ready = (rst_n && space) ? gnt : '0;
    sel_data = in_data[int'(pick_idx) * WIDTH +: WIDTH];
  end

  // Output register and round-robin pointer; ptr only moves on an accepted word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= CH_W'(NUM_CH - 1);
    end else if (in_xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_ch    <= pick_idx;
      if (MODE == ARB_RR) ptr <= pick_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
